alu_multicycle: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit alu_control codes and adds XOR/NOR/SRL/SRA/SLTU.
- Adds iterative signed/unsigned multiply and divide with HI/LO results.
- Uses a valid/ready handshake on both input and output so the control unit can stall on multi-cycle ops. Sits in the EX stage between the register-file read muxes and writeback/HI-LO registers.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_muldiv.sv | 86 ++++++++
 rtl/alu_multicycle.sv | 192 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, constants and FSM state type for the multi-cycle EX-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] OpAnd   = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] OpOr    = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] OpAdd   = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] OpXor   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] OpMult  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] OpMultu = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] OpSub   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] OpSlt   = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] OpSltu  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] OpDiv   = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] OpDivu  = 4'b1011;
    localparam logic [ALU_CTRL_W-1:0] OpNor   = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] OpSrl   = 4'b1101;
    localparam logic [ALU_CTRL_W-1:0] OpSra   = 4'b1110;
    localparam logic [ALU_CTRL_W-1:0] OpSll   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi_o/lo_o show the value produced by the current step, valid when done_o pulses.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
    logic               last;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        last     = busy_q && (cnt_q == CntW'(WIDTH - 1));
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        is_div_d = is_div_q;
        if (start_i) begin
            acc_d    = {{WIDTH{1'b0}}, a_i};
            b_d      = b_i;
            is_div_d = is_div_i;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    assign done_o        = last;
    assign {hi_o, lo_o}  = acc_step;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle ops plus iterative MULT/DIV behind a valid/ready handshake.
// Results and flags are registered and only change when entering DONE.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      op1,
    input  logic [WIDTH-1:0]      op2,
    input  logic [SHW-1:0]        shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result_lo,
    output logic [WIDTH-1:0]      result_hi,
    output logic                  zero_flag,
    output logic                  ovf_flag,
    output logic                  dz_flag,
    output logic                  illegal_op
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, div_q, div_d;

    logic               accept, is_div, is_signed, is_iter, div_zero, eng_start, eng_done;
    logic [WIDTH-1:0]   a_mag, b_mag, eng_hi, eng_lo, sum, diff;
    logic [WIDTH-1:0]   sc_lo, sc_hi, fin_lo, fin_hi;
    logic               sc_ovf, sc_dz, sc_ill;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        is_div    = (alu_control == OpDiv) || (alu_control == OpDivu);
        is_signed = (alu_control == OpDiv) || (alu_control == OpMult);
        is_iter   = is_div || (alu_control == OpMult) || (alu_control == OpMultu);
        div_zero  = is_div && (op2 == '0);
        a_mag     = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
        b_mag     = (is_signed && op2[WIDTH-1]) ? -op2 : op2;
        in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
        accept    = in_valid && in_ready;
        eng_start = accept && is_iter && !div_zero;
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (eng_start),
        .is_div_i (is_div),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (eng_done),
        .hi_o     (eng_hi),
        .lo_o     (eng_lo)
    );

    always_comb begin
        sum    = op1 + op2;
        diff   = op1 - op2;
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        case (alu_control)
            OpAdd: begin
                sc_lo  = sum;
                sc_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OpSub: begin
                sc_lo  = diff;
                sc_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OpAnd:  sc_lo = op1 & op2;
            OpOr:   sc_lo = op1 | op2;
            OpXor:  sc_lo = op1 ^ op2;
            OpNor:  sc_lo = ~(op1 | op2);
            OpSlt:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OpSltu: sc_lo = {{(WIDTH-1){1'b0}}, op1 < op2};
            OpSll:  sc_lo = op2 << shamt;
            OpSrl:  sc_lo = op2 >> shamt;
            OpSra:  sc_lo = $unsigned($signed(op2) >>> shamt);
            // Only reaches the result registers on divide-by-zero.
            OpDiv, OpDivu: begin
                sc_lo = '1;
                sc_hi = op1;
                sc_dz = 1'b1;
            end
            OpMult, OpMultu: ;
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        prod = {eng_hi, eng_lo};
        if (div_q) begin
            fin_lo = neg_lo_q ? -eng_lo : eng_lo;
            fin_hi = neg_hi_q ? -eng_hi : eng_hi;
        end else begin
            {fin_hi, fin_lo} = neg_lo_q ? -prod : prod;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div_d    = div_q;
        case (state_q)
            StBusy: begin
                if (eng_done) begin
                    state_d = StDone;
                    lo_d    = fin_lo;
                    hi_d    = fin_hi;
                    zero_d  = (fin_lo == '0);
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            StIdle, StDone: begin
                if (accept) begin
                    neg_lo_d = is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    neg_hi_d = is_signed && op1[WIDTH-1];
                    div_d    = is_div;
                    if (eng_start) begin
                        state_d = StBusy;
                    end else begin
                        state_d = StDone;
                        lo_d    = sc_lo;
                        hi_d    = sc_hi;
                        zero_d  = (sc_lo == '0);
                        ovf_d   = sc_ovf;
                        dz_d    = sc_dz;
                        ill_d   = sc_ill;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div_q    <= div_d;
        end
    end

    assign out_valid  = (state_q == StDone);
    assign result_lo  = lo_q;
    assign result_hi  = hi_q;
    assign zero_flag  = zero_q;
    assign ovf_flag   = ovf_q;
    assign dz_flag    = dz_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results, monitor pops on out_valid.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_control;
    logic [31:0] op1, op2, result_lo, result_hi;
    logic [4:0]  shamt;
    logic        zero_flag, ovf_flag, dz_flag, illegal_op;

    logic        v16, rdy16, ov16, ordy16, z16, o16, d16, i16;
    logic [3:0]  ctl16, sh16;
    logic [15:0] a16, b16, lo16, hi16;

    alu_multicycle #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op1(op1), .op2(op2), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo),
        .result_hi(result_hi), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
        .dz_flag(dz_flag), .illegal_op(illegal_op)
    );

    alu_multicycle #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
        .alu_control(ctl16), .op1(a16), .op2(b16), .shamt(sh16),
        .out_valid(ov16), .out_ready(ordy16), .result_lo(lo16),
        .result_hi(hi16), .zero_flag(z16), .ovf_flag(o16),
        .dz_flag(d16), .illegal_op(i16)
    );

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero, ovf, dz, ill;
        logic [31:0] lat;
        logic [63:0] acc;
    } exp_t;

    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    exp_t        sb[$];
    exp_t        mon_e;
    int          nerr = 0;
    int          nchk = 0;
    logic [63:0] cyc = 0;
    logic [63:0] acc16;
    bit          bp_rand = 1'b0;
    bit          fresh = 1'b1;
    logic        forced_rdy = 1'b1;
    logic        rand_rdy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rand_rdy <= ($urandom_range(0, 3) != 0);
    assign out_ready = bp_rand ? rand_rdy : forced_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic straight from the opcode rules.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        longint      sa, sb_, r;
        logic [63:0] p;
        e   = '0;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.lat = 1;
        case (op)
            OpAdd: begin r = sa + sb_; e.lo = a + b; e.ovf = (r > SMax) || (r < SMin); end
            OpSub: begin r = sa - sb_; e.lo = a - b; e.ovf = (r > SMax) || (r < SMin); end
            OpAnd:  e.lo = a & b;
            OpOr:   e.lo = a | b;
            OpXor:  e.lo = a ^ b;
            OpNor:  e.lo = ~(a | b);
            OpSlt:  e.lo = (sa < sb_) ? 32'd1 : 32'd0;
            OpSltu: e.lo = (a < b) ? 32'd1 : 32'd0;
            OpSll:  e.lo = b << sh;
            OpSrl:  e.lo = b >> sh;
            OpSra:  begin r = sb_ >>> sh; e.lo = r[31:0]; end
            OpMult: begin p = sa * sb_; {e.hi, e.lo} = p; e.lat = 33; end
            OpMultu: begin p = {32'h0, a} * {32'h0, b}; {e.hi, e.lo} = p; e.lat = 33; end
            OpDiv: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    // 64-bit math makes MIN / -1 give quotient MIN, remainder 0 after truncation.
                    r = sa / sb_; e.lo = r[31:0];
                    r = sa % sb_; e.hi = r[31:0];
                    e.lat = 33;
                end
            end
            OpDivu: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = 33;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.lo == 0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a falling edge; returns one falling edge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        exp_t e;
        int   waitc = 0;
        in_valid = 1'b1; alu_control = op; op1 = a; op2 = b; shamt = sh;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        e = model(op, a, b, sh);
        e.acc = cyc;
        if (in_ready) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; alu_control = 4'($urandom); shamt = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst_n || !out_valid) begin
            fresh = 1'b1;
        end else if (sb.size() == 0) begin
            chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
            mon_e = sb[0];
            if (fresh) chk("latency", cyc - mon_e.acc, 64'(mon_e.lat));
            chk("result_lo", 64'(result_lo), 64'(mon_e.lo));
            chk("result_hi", 64'(result_hi), 64'(mon_e.hi));
            chk("zero_flag", {63'd0, zero_flag}, {63'd0, mon_e.zero});
            chk("ovf_flag", {63'd0, ovf_flag}, {63'd0, mon_e.ovf});
            chk("dz_flag", {63'd0, dz_flag}, {63'd0, mon_e.dz});
            chk("illegal_op", {63'd0, illegal_op}, {63'd0, mon_e.ill});
            if (out_ready) begin
                void'(sb.pop_front());
                fresh = 1'b1;
            end else begin
                fresh = 1'b0;
            end
        end
    end

    initial begin
        int n;
        in_valid = 0; alu_control = 0; op1 = 0; op2 = 0; shamt = 0;
        v16 = 0; ctl16 = 0; a16 = 0; b16 = 0; sh16 = 0; ordy16 = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_result", {result_hi, result_lo}, 64'd0);
        chk("rst_flags", {60'd0, zero_flag, ovf_flag, dz_flag, illegal_op}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        issue(OpAdd, 32'h7FFF_FFFF, 32'h1, 5'd0);
        issue(OpSub, 32'd5, 32'd5, 5'd0);
        drain();

        // Abort a MULT in its tenth BUSY cycle; nothing may come out afterwards.
        issue(OpMult, 32'd3, 32'd5, 5'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #2;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_result", {result_hi, result_lo}, 64'd0);
        chk("abort_flags", {60'd0, zero_flag, ovf_flag, dz_flag, illegal_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("abort_rel_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);

        issue(OpMult, 32'hFFFF_FFFD, 32'd7, 5'd0);
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd0);
        issue(OpDivu, 32'd100, 32'd0, 5'd0);
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        drain();

        // Backpressure, then a back-to-back accept in the release cycle.
        forced_rdy = 1'b0;
        issue(OpSlt, 32'hFFFF_FFFF, 32'd1, 5'd0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        forced_rdy = 1'b1;
        #0;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        issue(OpSra, 32'd0, 32'h8000_0000, 5'd4);
        drain();

        ctl16 = OpMultu; a16 = 16'hFFFF; b16 = 16'h0002;
        chk("w16_in_ready", {63'd0, rdy16}, 64'd1);
        v16 = 1'b1;
        acc16 = cyc;
        @(negedge clk);
        v16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
        n = 0;
        while (!ov16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("w16_latency", cyc - acc16, 64'd17);
        chk("w16_result", {32'd0, hi16, lo16}, 64'h0001_FFFE);
        chk("w16_flags", {60'd0, z16, o16, d16, i16}, 64'd0);
        @(negedge clk);

        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(4'($urandom), rnd_op(), ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_op(),
                  5'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
